fb_rect_fill: RTL and testbench

- Hardware rectangle fill engine that sits directly upstream of the VGA framebuffer RAM. It is the producer of framebuffer word writes.
- The CPU programs corner coordinates and a colour over Avalon, then starts the engine. The engine walks the rectangle row by row and emits 32-pixel word writes.
- Partially covered words are updated by read-modify-write through the framebuffer's second read port.
- The framebuffer write port is muxed downstream; the engine owns it while busy=1.

---
 rtl/fb_rect_fill.sv | 168 ++++++++++++++++
 tb/tb_fb_rect_fill.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_fill.sv
// rtl/fb_rect_fill.sv - rectangle fill engine producing framebuffer word writes (optional XOR mode: FILL_XOR_EN)
module fb_rect_fill #(
  parameter int WORDS_PER_ROW = 20,
  parameter int H_PIXELS      = 640,
  parameter int V_PIXELS      = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [14:0] fb_wraddress,
  output logic [31:0] fb_wrdata,
  output logic        fb_wren,
  output logic [14:0] fb_rdaddress,
  input  logic [31:0] fb_q,
  output logic        busy
);

  localparam logic [9:0]  H_LIM = H_PIXELS[9:0];
  localparam logic [8:0]  V_LIM = V_PIXELS[8:0];
  localparam logic [14:0] WPR   = WORDS_PER_ROW[14:0];
  localparam logic [5:0]  WPR_S = WORDS_PER_ROW[5:0];

  typedef enum logic [2:0] {IDLE, SETUP, RD, WAIT, WR, NEXT} state_t;
  state_t state, state_nx;

  logic [9:0]  x0_r, x1_r;
  logic [8:0]  y0_r, y1_r, row;
  logic        color_r, xor_r;
  logic [4:0]  word;
  logic [14:0] base;
  logic [31:0] rd_data;
  logic        done_r, err_r;

  wire unused_wdata = &{1'b0, writedata[31:10]};

  wire        idle     = (state == IDLE);
  wire        reg_wr   = chipselect & write & idle;
  wire        ctrl_wr  = reg_wr && (address == 3'd4);
  wire        start    = ctrl_wr && writedata[0];
  wire        cmd_bad  = (x0_r > x1_r) || (y0_r > y1_r) || (x1_r >= H_LIM) || (y1_r >= V_LIM);
  wire [4:0]  wl       = x0_r[9:5];
  wire [4:0]  wr       = x1_r[9:5];
  wire        row_end  = (word == wr);
  wire        last     = row_end && (row == y1_r);
  wire [4:0]  nxt_word = row_end ? wl : word + 5'd1;

  // Coverage of word w: left edge clipped on the first word, right edge on the last.
  function automatic logic [31:0] mask_of(input logic [4:0] w);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    if (w == wl) m = m & (32'hFFFF_FFFF << x0_r[4:0]);
    if (w == wr) m = m & (32'hFFFF_FFFF >> (5'd31 - x1_r[4:0]));
    return m;
  endfunction

  // Fully covered words need no read; their data is known outright.
  function automatic logic direct(input logic [4:0] w);
    return (mask_of(w) == 32'hFFFF_FFFF) && !xor_r;
  endfunction

  // y * WORDS_PER_ROW as a sum of shifted copies of y, one term per set bit of the row pitch.
  function automatic logic [14:0] row_base(input logic [8:0] y);
    logic [14:0] acc;
    acc = '0;
    for (int i = 0; i < 6; i++)
      if (WPR_S[i]) acc = acc + (15'(y) << i);
    return acc;
  endfunction

  wire [31:0] cur_mask = mask_of(word);
  wire [31:0] wr_value = xor_r ? (rd_data ^ cur_mask)
                               : ((rd_data & ~cur_mask) | (color_r ? cur_mask : 32'h0));

  assign busy         = !idle;
  assign readdata     = {29'h0, err_r, done_r, busy};
  assign fb_rdaddress = base + 15'(word);
  assign fb_wraddress = base + 15'(word);

`ifdef FILL_XOR_EN
  // XOR mode is captured together with the colour on every control write.
  always_ff @(posedge clk or posedge reset)
    if (reset)        xor_r <= 1'b0;
    else if (ctrl_wr) xor_r <= writedata[2];
`else
  assign xor_r = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  // Next-state decode and write-port drive.
  always_comb begin
    state_nx  = state;
    fb_wren   = 1'b0;
    fb_wrdata = 32'h0;
    case (state)
      IDLE:  if (start && !cmd_bad) state_nx = SETUP;
      SETUP: state_nx = direct(wl) ? WR : RD;
      RD:    state_nx = WAIT;
      WAIT:  state_nx = WR;
      WR: begin
        fb_wren   = 1'b1;
        fb_wrdata = wr_value;
        state_nx  = NEXT;
      end
      NEXT:  state_nx = last ? IDLE : (direct(nxt_word) ? WR : RD);
      default: state_nx = IDLE;
    endcase
  end

  // Register file, status flags and the row/word walk.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      x0_r    <= '0;
      x1_r    <= '0;
      y0_r    <= '0;
      y1_r    <= '0;
      color_r <= 1'b0;
      row     <= '0;
      word    <= '0;
      base    <= '0;
      rd_data <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (reg_wr) begin
        case (address)
          3'd0: x0_r <= writedata[9:0];
          3'd1: y0_r <= writedata[8:0];
          3'd2: x1_r <= writedata[9:0];
          3'd3: y1_r <= writedata[8:0];
          3'd4: color_r <= writedata[1];
          default: ;
        endcase
      end
      if (start) begin
        done_r <= 1'b0;
        err_r  <= cmd_bad;
      end
      case (state)
        SETUP: begin
          row  <= y0_r;
          base <= row_base(y0_r);
          word <= wl;
        end
        WAIT: rd_data <= fb_q;
        NEXT: begin
          if (last) begin
            done_r <= 1'b1;
          end else if (row_end) begin
            word <= wl;
            row  <= row + 9'd1;
            base <= base + WPR;
          end else begin
            word <= word + 5'd1;
          end
        end
        default: ;
      endcase
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// tb/tb_fb_rect_fill.sv - scoreboard bench for fb_rect_fill against a pixel-level reference model
module tb_fb_rect_fill;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, write;
  logic [2:0]  address;
  logic [31:0] writedata, readdata;
  logic [14:0] fb_wraddress, fb_rdaddress;
  logic [31:0] fb_wrdata, fb_q;
  logic        fb_wren, busy;

  fb_rect_fill dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .fb_wraddress(fb_wraddress), .fb_wrdata(fb_wrdata), .fb_wren(fb_wren),
    .fb_rdaddress(fb_rdaddress), .fb_q(fb_q), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef struct { logic [14:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  wr_t         e_mon;
  logic [31:0] ram  [0:16383];
  logic [31:0] refm [0:16383];
  int          vectors = 0;
  int          errs    = 0;

  // Framebuffer model: registered read port, write port updating the array.
  always @(posedge clk) begin
    fb_q <= ram[fb_rdaddress];
    if (fb_wren) ram[fb_wraddress] = fb_wrdata;
  end

  // Monitor: every write pulse must match the next expected write.
  always @(negedge clk) begin
    if (fb_wren === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_write addr=%0d data=%h (no write expected)", fb_wraddress, fb_wrdata);
      end else begin
        e_mon = exp_q.pop_front();
        if (e_mon.a !== fb_wraddress || e_mon.d !== fb_wrdata) begin
          errs++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                   fb_wraddress, fb_wrdata, e_mon.a, e_mon.d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic av_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic prog(input int x0, input int y0, input int x1, input int y1);
    av_wr(3'd0, 32'(x0));
    av_wr(3'd1, 32'(y0));
    av_wr(3'd2, 32'(x1));
    av_wr(3'd3, 32'(y1));
  endtask

  task automatic start(input logic color, input logic xm);
    av_wr(3'd4, {29'h0, xm, color, 1'b1});
  endtask

  // Reference: each pixel x0..x1 of each row y0..y1 is set, cleared or toggled.
  task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                           input logic color, input logic xm);
    logic [31:0] m, d;
    int a;
    for (int y = y0; y <= y1; y++)
      for (int w = x0 / 32; w <= x1 / 32; w++) begin
        m = 32'h0;
        for (int b = 0; b < 32; b++)
          if (w * 32 + b >= x0 && w * 32 + b <= x1) m[b] = 1'b1;
        a = y * 20 + w;
        d = xm ? (refm[a] ^ m) : ((refm[a] & ~m) | (color ? m : 32'h0));
        refm[a] = d;
        exp_q.push_back('{a: 15'(a), d: d});
      end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_drop"}, {31'h0, busy}, 32'h0);
    check({name, "_status"}, readdata, 32'h2);
    check({name, "_pending"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic run_valid(input string name, input int x0, input int y0, input int x1, input int y1,
                           input logic color, input logic xm, input int budget);
    prog(x0, y0, x1, y1);
    push_rect(x0, y0, x1, y1, color, xm);
    start(color, xm);
    check({name, "_busy_rise"}, readdata, 32'h1);
    wait_done(name, budget);
  endtask

  task automatic run_bad(input string name, input int x0, input int y0, input int x1, input int y1);
    prog(x0, y0, x1, y1);
    start(1'b1, 1'b0);
    check({name, "_error"}, readdata, 32'h4);
    repeat (5) @(negedge clk);
    check({name, "_still_idle"}, readdata, 32'h4);
  endtask

  task automatic set_word(input int a, input logic [31:0] v);
    ram[a]  = v;
    refm[a] = v;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int x0, y0, x1, y1;
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
    for (int i = 0; i < 16384; i++) set_word(i, $urandom);
    #1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_wren", {31'h0, fb_wren}, 32'h0);
    check("reset_wraddr", {17'h0, fb_wraddress}, 32'h0);
    check("reset_rdaddr", {17'h0, fb_rdaddress}, 32'h0);
    check("reset_wrdata", fb_wrdata, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    run_valid("full_screen", 0, 0, 639, 479, 1'b1, 1'b0, 25000);
    check("full_screen_first", ram[0], 32'hFFFF_FFFF);
    check("full_screen_last", ram[9599], 32'hFFFF_FFFF);

    set_word(20, 32'h8000_0000);
    run_valid("partial", 3, 1, 5, 1, 1'b1, 1'b0, 100);
    check("partial_word20", ram[20], 32'h8000_0038);

    set_word(40, 32'h0); set_word(41, 32'h0);
    run_valid("straddle_set", 30, 2, 33, 2, 1'b1, 1'b0, 100);
    check("straddle_set_w40", ram[40], 32'hC000_0000);
    check("straddle_set_w41", ram[41], 32'h0000_0003);
    set_word(40, 32'hFFFF_FFFF); set_word(41, 32'hFFFF_FFFF);
    run_valid("straddle_clr", 30, 2, 33, 2, 1'b0, 1'b0, 100);
    check("straddle_clr_w40", ram[40], 32'h3FFF_FFFF);
    check("straddle_clr_w41", ram[41], 32'hFFFF_FFFC);

    run_bad("bad_x_order", 10, 0, 5, 0);
    run_bad("bad_y_order", 0, 9, 5, 8);
    run_bad("bad_x1_range", 0, 0, 640, 0);
    run_bad("bad_y1_range", 0, 0, 5, 480);

    // Mid-fill start and register writes must not disturb the running command.
    prog(7, 5, 600, 9);
    push_rect(7, 5, 600, 9, 1'b1, 1'b0);
    start(1'b1, 1'b0);
    check("midfill_busy_rise", readdata, 32'h1);
    prog(100, 100, 200, 110);
    start(1'b0, 1'b0);
    wait_done("midfill", 2000);
    push_rect(7, 5, 600, 9, 1'b1, 1'b0);
    start(1'b1, 1'b0);
    wait_done("midfill_regs_kept", 2000);

    // Reset lands while the engine waits for read data.
    prog(3, 1, 5, 1);
    start(1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_reset_busy", readdata, 32'h1);
    reset = 1'b1;
    #1;
    check("midreset_wren", {31'h0, fb_wren}, 32'h0);
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_status", readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_status", readdata, 32'h0);
    set_word(20, 32'h0000_0100);
    run_valid("after_reset", 3, 1, 5, 1, 1'b1, 1'b0, 100);
    check("after_reset_word20", ram[20], 32'h0000_0138);

    for (int t = 0; t < 24; t++) begin
      x0 = $urandom_range(0, 639);
      x1 = $urandom_range(x0, (x0 + 120 > 639) ? 639 : x0 + 120);
      y0 = $urandom_range(0, 479);
      y1 = $urandom_range(y0, (y0 + 3 > 479) ? 479 : y0 + 3);
      run_valid("random", x0, y0, x1, y1, 1'($urandom_range(0, 1)), 1'b0, 500);
    end

`ifdef FILL_XOR_EN
    set_word(0, 32'h0F0F_0F0F);
    run_valid("xor_word", 0, 0, 31, 0, 1'b0, 1'b1, 100);
    check("xor_word0", ram[0], 32'hF0F0_F0F0);
    for (int t = 0; t < 8; t++) begin
      x0 = $urandom_range(0, 639);
      x1 = $urandom_range(x0, 639);
      y0 = $urandom_range(0, 478);
      run_valid("xor_random", x0, y0, x1, y0 + 1, 1'($urandom_range(0, 1)), 1'b1, 500);
    end
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
